// File: rtl/vga_pkg.sv
// Shared screen geometry, FSM state encoding and pixel colour type
// for the VGA ball renderer.
package vga_pkg;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned V_ACTIVE = 480;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } ball_state_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

endpackage

// File: rtl/vga_ball_axis.sv
// One axis of ball motion: position/direction registers, centre reload
// and the per-frame step with wall clamp and bounce flag.
module vga_ball_axis #(
   parameter int unsigned MAX   = 624,
   parameter int unsigned STEP  = 2,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_center,
   input  logic             move,
   output logic [WIDTH-1:0] pos_o,
   output logic             bounce_o
);

   localparam logic [WIDTH-1:0] CENTER = WIDTH'(MAX / 2);
   localparam logic [WIDTH-1:0] MAXW   = WIDTH'(MAX);
   localparam logic [10:0]      MAX11  = 11'(MAX);
   localparam logic [10:0]      STEP11 = 11'(STEP);

   logic [WIDTH-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;   // 1 = increasing coordinate
   logic [10:0]      pos11, sum11;

   always_comb begin
      pos11    = 11'(pos_q);
      sum11    = pos11 + STEP11;
      pos_d    = pos_q;
      dir_d    = dir_q;
      bounce_o = 1'b0;
      if (load_center) begin
         pos_d = CENTER;
         dir_d = 1'b1;
      end else if (move) begin
         if (dir_q) begin
            if (sum11 >= MAX11) begin
               pos_d    = MAXW;
               dir_d    = 1'b0;
               bounce_o = 1'b1;
            end else begin
               pos_d = sum11[WIDTH-1:0];
            end
         end else begin
            if (pos11 <= STEP11) begin
               pos_d    = '0;
               dir_d    = 1'b1;
               bounce_o = 1'b1;
            end else begin
               pos_d = WIDTH'(pos11 - STEP11);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos_q <= CENTER;
         dir_q <= 1'b1;
      end else begin
         pos_q <= pos_d;
         dir_q <= dir_d;
      end
   end

   assign pos_o = pos_q;

endmodule

// File: rtl/vga_ball_renderer.sv
// Square bouncing ball over a solid background; one move per frame on the
// VS falling edge, gated by an IDLE/RUN/PAUSED control FSM.
module vga_ball_renderer
   import vga_pkg::*;
#(
   parameter int unsigned BALL_SIZE  = 16,
   parameter int unsigned STEP       = 2,
   parameter logic [23:0] BALL_COLOR = 24'hFFFF00,
   parameter logic [23:0] BG_COLOR   = 24'h000040
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [8:0] row,
   input  logic [9:0] col,
   input  logic       blank,
   input  logic       VS,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [7:0] red,
   output logic [7:0] green,
   output logic [7:0] blue,
   output logic [7:0] bounce_count,
   output logic [1:0] state
);

   logic        vs_q;
   logic        frame_tick, move;
   ball_state_t state_q, state_d;
   logic [7:0]  bc_q, bc_d;
   logic [8:0]  bc_sum;
   rgb_t        rgb_q, rgb_d;
   logic [9:0]  ball_x;
   logic [8:0]  ball_y;
   logic        bounce_x, bounce_y;
   logic        hit;

   assign frame_tick = vs_q & ~VS;
   // Motion uses the registered state, so a pause on a tick edge still moves once.
   assign move       = frame_tick && (state_q == RUN);

   vga_ball_axis #(.MAX(H_ACTIVE - BALL_SIZE), .STEP(STEP), .WIDTH(10)) u_axis_x (
      .clk(CLOCK_50), .rst(reset), .load_center(clear), .move(move),
      .pos_o(ball_x), .bounce_o(bounce_x)
   );

   vga_ball_axis #(.MAX(V_ACTIVE - BALL_SIZE), .STEP(STEP), .WIDTH(9)) u_axis_y (
      .clk(CLOCK_50), .rst(reset), .load_center(clear), .move(move),
      .pos_o(ball_y), .bounce_o(bounce_y)
   );

   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (pause) state_d = PAUSED;
            PAUSED:  if (pause || start) state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bc_sum = {1'b0, bc_q} + 9'(bounce_x) + 9'(bounce_y);
      if (clear)        bc_d = '0;
      else if (bc_sum[8]) bc_d = '1;
      else              bc_d = bc_sum[7:0];
   end

   always_comb begin
      hit = (col >= ball_x) && (11'(col) < 11'(ball_x) + 11'(BALL_SIZE)) &&
            (row >= ball_y) && (10'(row) < 10'(ball_y) + 10'(BALL_SIZE));
      if (blank)    rgb_d = '0;
      else if (hit) rgb_d = rgb_t'(BALL_COLOR);
      else          rgb_d = rgb_t'(BG_COLOR);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         vs_q    <= 1'b1;
         state_q <= IDLE;
         bc_q    <= '0;
         rgb_q   <= '0;
      end else begin
         vs_q    <= VS;
         state_q <= state_d;
         bc_q    <= bc_d;
         rgb_q   <= rgb_d;
      end
   end

   assign red          = rgb_q.r;
   assign green        = rgb_q.g;
   assign blue         = rgb_q.b;
   assign bounce_count = bc_q;
   assign state        = state_q;

endmodule

// File: tb/tb_vga_ball_renderer.sv
// Self-checking bench for vga_ball_renderer: directed steps plus random
// actions compared against a frame-level behavioural model.
module tb_vga_ball_renderer;

   localparam int S    = 16;
   localparam int ST   = 2;
   localparam int XMAX = 640 - S;
   localparam int YMAX = 480 - S;
   localparam logic [23:0] BALLC = 24'hFFFF00;
   localparam logic [23:0] BGC   = 24'h000040;

   logic       CLOCK_50 = 1'b0;
   logic       reset = 1'b1;
   logic [8:0] row = '0;
   logic [9:0] col = '0;
   logic       blank = 1'b1, VS = 1'b1, start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [7:0] red, green, blue, bounce_count;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;
   int mx, my, mdx, mdy, mbc, mst;

   always #10 CLOCK_50 = ~CLOCK_50;

   vga_ball_renderer #(
      .BALL_SIZE(S), .STEP(ST), .BALL_COLOR(BALLC), .BG_COLOR(BGC)
   ) dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .row(row), .col(col), .blank(blank),
      .VS(VS), .start(start), .pause(pause), .clear(clear),
      .red(red), .green(green), .blue(blue),
      .bounce_count(bounce_count), .state(state)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mx = (640 - S) / 2; my = (480 - S) / 2;
      mdx = 1; mdy = 1; mbc = 0; mst = 0;
   endtask

   task automatic axis(inout int p, inout int d, input int lim, inout int b);
      if (d > 0) begin
         if (p + ST >= lim) begin p = lim; d = -1; b++; end
         else p = p + ST;
      end else begin
         if (p <= ST) begin p = 0; d = 1; b++; end
         else p = p - ST;
      end
   endtask

   function automatic logic [23:0] pix(int r, int c, bit bl);
      if (bl) return 24'h0;
      if (c >= mx && c < mx + S && r >= my && r < my + S) return BALLC;
      return BGC;
   endfunction

   task automatic probe(input int r, input int c, input bit bl, input string tag);
      row = 9'(r); col = 10'(c); blank = bl;
      @(negedge CLOCK_50);
      chk(tag, {8'h0, red, green, blue}, {8'h0, pix(r, c, bl)});
   endtask

   task automatic check_ball(input string tag);
      probe(my, mx, 0, {tag, ":tl"});
      probe(my + S - 1, mx + S - 1, 0, {tag, ":br"});
      if (mx > 0)       probe(my, mx - 1, 0, {tag, ":left"});
      if (mx + S < 640) probe(my, mx + S, 0, {tag, ":right"});
      if (my > 0)       probe(my - 1, mx, 0, {tag, ":above"});
      if (my + S < 480) probe(my + S, mx, 0, {tag, ":below"});
      chk({tag, ":state"}, {30'h0, state}, mst);
      chk({tag, ":bounces"}, {24'h0, bounce_count}, mbc);
   endtask

   // One control cycle with optional VS falling edge and pulses, then VS restored.
   task automatic act(input bit fr, input bit st, input bit pa, input bit cl);
      int b;
      VS = fr ? 1'b0 : 1'b1; start = st; pause = pa; clear = cl;
      @(negedge CLOCK_50);
      VS = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
      if (cl) begin
         model_reset();
      end else begin
         if (fr && mst == 1) begin
            b = 0;
            axis(mx, mdx, XMAX, b);
            axis(my, mdy, YMAX, b);
            mbc = (mbc + b > 255) ? 255 : mbc + b;
         end
         case (mst)
            0: if (st) mst = 1;
            1: if (pa) mst = 2;
            2: if (pa || st) mst = 1;
            default: mst = 0;
         endcase
      end
      @(negedge CLOCK_50);
   endtask

   initial begin
      int r;
      model_reset();
      // reset held with arbitrary inputs
      blank = 1'b0; row = 9'd240; col = 10'd320;
      repeat (3) @(negedge CLOCK_50);
      chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
      chk("rst_state", {30'h0, state}, 32'h0);
      chk("rst_bc", {24'h0, bounce_count}, 32'h0);
      reset = 1'b0;
      check_ball("reset_centre");

      // async reset mid-line clears RGB before the next edge
      probe(240, 320, 0, "pre_async");
      #3 reset = 1'b1;
      #1 chk("async_rgb", {8'h0, red, green, blue}, 32'h0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      model_reset();

      probe(240, 320, 0, "centre_px");
      probe(240, 100, 0, "bg_px");
      probe(240, 320, 1, "blank_px");
      probe(240, 311, 0, "col311");
      probe(240, 312, 0, "col312");
      probe(240, 327, 0, "col327");
      probe(240, 328, 0, "col328");
      probe(231, 320, 0, "row231");
      probe(247, 320, 0, "row247");
      probe(248, 320, 0, "row248");

      act(1, 0, 1, 0);
      check_ball("idle_no_move");
      act(0, 1, 0, 0);
      repeat (3) act(1, 0, 0, 0);
      check_ball("three_frames");
      row = 9'd0; col = 10'd0; blank = 1'b1;
      repeat (10000) @(negedge CLOCK_50);
      check_ball("no_vs");

      repeat (113) act(1, 0, 0, 0);
      check_ball("frame116");
      repeat (40) act(1, 0, 0, 0);
      check_ball("frame156");

      act(1, 0, 1, 0);
      check_ball("pause_on_tick");
      repeat (2) act(1, 0, 0, 0);
      check_ball("paused_hold");
      act(0, 0, 1, 0);
      act(1, 0, 0, 0);
      check_ball("resumed");

      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 99);
         if (r < 60)      act(1, 0, 0, 0);
         else if (r < 68) act(0, 1, 0, 0);
         else if (r < 76) act(0, 0, 1, 0);
         else if (r < 79) act(0, 0, 0, 1);
         else if (r < 84) act(1, 0, 1, 0);
         else probe($urandom_range(0, 479), $urandom_range(0, 639),
                    ($urandom_range(0, 7) == 0), "rand_px");
         if (i % 25 == 24) check_ball("rand_ball");
      end

      act(0, 1, 0, 0);
      repeat (200) act(1, 0, 0, 0);
      check_ball("long_run");
      act(0, 1, 0, 1);
      check_ball("clear_start");
      repeat (3) act(1, 0, 0, 0);
      check_ball("cleared_idle");

      act(0, 1, 0, 0);
      repeat (30) act(1, 0, 0, 0);
      probe(my, mx, 0, "pre_async2");
      #3 reset = 1'b1;
      #1 chk("async2_rgb", {8'h0, red, green, blue}, 32'h0);
      chk("async2_state", {30'h0, state}, 32'h0);
      chk("async2_bc", {24'h0, bounce_count}, 32'h0);
      @(negedge CLOCK_50);
      reset = 1'b0;
      model_reset();
      check_ball("after_reset2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
